tt_path_engine: RTL
===================

# tt_path_engine

Parametrised hop-count shortest-path engine, next generation of the 16-node transport-cost core. It accepts one query (source, destination) followed by a streamed edge list, runs a level-synchronous breadth-first search over an internal adjacency matrix, and returns the minimum hop count plus a reachability flag. It sits inside the chip shell behind the input/output pads, and adds configurable node count, a directed-graph mode and an explicit `reach` output.

## Interface
- `N_NODES`, 16: number of graph nodes, 2..64.
- `ID_W`, 4: node-id width; must be ≥ clog2(N_NODES).
- `COST_W`, 4: cost width; must be ≥ clog2(N_NODES).
- `DIRECTED`, 0: 0 = each edge stored both ways (a↔b); 1 = edge stored only as source→destination.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: frame valid; high for one contiguous burst per query.
- `source` in ID_W: query source on frame cycle 0, edge tail on later cycles.
- `destination` in ID_W: query destination on frame cycle 0, edge head on later cycles.
- `out_valid` out 1: one-cycle result strobe.
- `cost` out COST_W: minimum hop count; 0 when unreachable or source == destination.
- `reach` out 1: 1 if the destination is reachable from the source (including source == destination).

## Operation
- Storage:
  - adjacency matrix `adj`, N_NODES×N_NODES bits;
  - `frontier` and `visited`, N_NODES bits each;
  - `level` counter, COST_W bits;
  - `q_src`, `q_dst` registers.
- FSM states: IDLE, LOAD, SEARCH, OUT.
- IDLE:
  - On `in_valid`=1, latch `q_src`/`q_dst`, clear all of `adj`, go to LOAD.
- LOAD:
  - On each cycle with `in_valid`=1, set adj[source][destination]. If DIRECTED=0, also set adj[destination][source].
  - Ignore an edge if either id is ≥ N_NODES. Self-loops and duplicate edges are harmless.
  - On the first cycle with `in_valid`=0, load frontier = visited = onehot(q_src), set level=0, go to SEARCH.
  - A frame with zero edges (in_valid high for one cycle) is legal.
- Query ids ≥ N_NODES: the result is reach=0, cost=0.
- SEARCH, each cycle:
  - If q_src == q_dst (checked on the first SEARCH cycle only): result cost=0, reach=1.
  - Otherwise compute next = (OR of adj rows selected by frontier) & ~visited.
  - If next[q_dst]: result cost=level+1, reach=1.
  - Else if next == 0: result cost=0, reach=0.
  - Else: frontier←next, visited|=next, level++.
  - On any result, register the outputs and go to OUT.
- OUT:
  - out_valid=1 for exactly one cycle, then go to IDLE.
  - `cost`/`reach` hold their value until the next out_valid. Checkers sample them only when out_valid=1.
- `in_valid` is ignored in SEARCH and OUT. The environment must not start a new frame before out_valid has pulsed; a frame begun during OUT is lost.
- Arithmetic: level never exceeds N_NODES−1, so there is no overflow at COST_W ≥ clog2(N_NODES).

## Timing
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; out_valid=0, cost=0, reach=0; adj, frontier, visited and level cleared.
  - Reset mid-LOAD or mid-SEARCH aborts the query; no out_valid is produced for it.
- Let t be the first cycle with in_valid=0 after the frame, which is the first SEARCH cycle.
  - source == destination: out_valid at t+1.
  - Reachable at hop distance k ≥ 1: out_valid at t+k.
  - Unreachable, with the search exhausted after expanding i levels: out_valid at t+i+1. Worst case is ≤ t+N_NODES.
- Back-to-back queries: in_valid may rise on the cycle after out_valid, since the engine is in IDLE again.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then a frame (src=3, dst=3) with no edges → out_valid at t+1, cost=0, reach=1.
- N_NODES=16, DIRECTED=0: query (0,5) with edges 0-1, 1-2, 2-5, 0-7 → out_valid at t+3, cost=3, reach=1.
- Same graph with DIRECTED=1, query (5,0) → cost=0, reach=0. Repeat with DIRECTED=0 → cost=3, reach=1.
- Chain 0-1-…-15 streamed in reverse order, query (0,15) → cost=15, reach=1, out_valid at t+15. Repeat with N_NODES=32, chain 0..31: cost=31.
- Disconnected graph {0-1, 2-3}, query (0,3) → cost=0, reach=0. Then an immediate back-to-back query (2,3) → cost=1, reach=1; the first query's edges do not persist.
- Assert rst during SEARCH of query (0,15) → no out_valid, outputs 0. A next query (0,1) with edge 0-1 → cost=1.

Source files
------------

// File: rtl/tt_path_engine.sv
// Hop-count shortest-path engine: streams an edge list into an adjacency matrix,
// then runs a level-synchronous BFS from q_src and reports the hop count to q_dst.
module tt_path_engine #(
    parameter int N_NODES  = 16,
    parameter int ID_W     = 4,
    parameter int COST_W   = 4,
    parameter int DIRECTED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ID_W-1:0]   source,
    input  logic [ID_W-1:0]   destination,
    output logic              out_valid,
    output logic [COST_W-1:0] cost,
    output logic              reach
);

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUT} state_t;

    state_t              state_q, state_d;
    logic [N_NODES-1:0]  adj_q [N_NODES];
    logic [N_NODES-1:0]  adj_d [N_NODES];
    logic [N_NODES-1:0]  frontier_q, frontier_d;
    logic [N_NODES-1:0]  visited_q, visited_d;
    logic [COST_W-1:0]   level_q, level_d;
    logic [ID_W-1:0]     q_src_q, q_src_d;
    logic [ID_W-1:0]     q_dst_q, q_dst_d;
    logic [COST_W-1:0]   cost_q, cost_d;
    logic                reach_q, reach_d;
    logic                out_valid_q, out_valid_d;

    logic [N_NODES-1:0]  src_oh, dst_oh, qsrc_oh, qdst_oh, next_set;
    logic                first_step;

    // Out-of-range ids decode to all-zero, which makes them inert everywhere.
    function automatic logic [N_NODES-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N_NODES-1:0] oh;
        for (int i = 0; i < N_NODES; i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

    always_comb begin
        state_d     = state_q;
        adj_d       = adj_q;
        frontier_d  = frontier_q;
        visited_d   = visited_q;
        level_d     = level_q;
        q_src_d     = q_src_q;
        q_dst_d     = q_dst_q;
        cost_d      = cost_q;
        reach_d     = reach_q;
        out_valid_d = 1'b0;

        src_oh     = onehot(source);
        dst_oh     = onehot(destination);
        qsrc_oh    = onehot(q_src_q);
        qdst_oh    = onehot(q_dst_q);
        first_step = (level_q == '0);

        next_set = '0;
        for (int i = 0; i < N_NODES; i++) begin
            if (frontier_q[i]) begin
                next_set = next_set | adj_q[i];
            end
        end
        next_set = next_set & ~visited_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_src_d = source;
                    q_dst_d = destination;
                    for (int i = 0; i < N_NODES; i++) begin
                        adj_d[i] = '0;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < N_NODES; i++) begin
                        for (int j = 0; j < N_NODES; j++) begin
                            if (src_oh[i] && dst_oh[j]) begin
                                adj_d[i][j] = 1'b1;
                            end
                            if ((DIRECTED == 0) && dst_oh[i] && src_oh[j]) begin
                                adj_d[i][j] = 1'b1;
                            end
                        end
                    end
                end else begin
                    frontier_d = qsrc_oh;
                    visited_d  = qsrc_oh;
                    level_d    = '0;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                state_d     = OUT;
                out_valid_d = 1'b1;
                // level is still zero only on the first search cycle
                if (first_step && ((qsrc_oh == '0) || (qdst_oh == '0))) begin
                    cost_d  = '0;
                    reach_d = 1'b0;
                end else if (first_step && (q_src_q == q_dst_q)) begin
                    cost_d  = '0;
                    reach_d = 1'b1;
                end else if ((next_set & qdst_oh) != '0) begin
                    cost_d  = level_q + COST_W'(1);
                    reach_d = 1'b1;
                end else if (next_set == '0) begin
                    cost_d  = '0;
                    reach_d = 1'b0;
                end else begin
                    frontier_d  = next_set;
                    visited_d   = visited_q | next_set;
                    level_d     = level_q + COST_W'(1);
                    state_d     = SEARCH;
                    out_valid_d = 1'b0;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < N_NODES; i++) begin
                adj_q[i] <= '0;
            end
            frontier_q  <= '0;
            visited_q   <= '0;
            level_q     <= '0;
            q_src_q     <= '0;
            q_dst_q     <= '0;
            cost_q      <= '0;
            reach_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            adj_q       <= adj_d;
            frontier_q  <= frontier_d;
            visited_q   <= visited_d;
            level_q     <= level_d;
            q_src_q     <= q_src_d;
            q_dst_q     <= q_dst_d;
            cost_q      <= cost_d;
            reach_q     <= reach_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cost      = cost_q;
    assign reach     = reach_q;

endmodule
